// File: rtl/car_light_ctrl_if.sv
// Switch/LED bundle between the board and car_light_ctrl.
// The board side (master) drives mode; the controller (slave) drives the LEDs.
interface car_light_ctrl_if #(
  parameter int LED_N = 8
);
  logic [1:0]       mode;
  logic [2:0]       ledRGB;
  logic [LED_N-1:0] ledWater;
  logic [1:0]       stateOut;

  modport master (output mode, input ledRGB, ledWater, stateOut);
  modport slave  (input mode, output ledRGB, ledWater, stateOut);
endinterface

// File: rtl/car_light_ctrl.sv
// Turn-signal / hazard light controller: debounced mode select, tick-paced
// centre-out fill sweep and blinking status LED; all outputs registered, active-low.
module car_light_ctrl #(
  parameter int LED_N = 8,
  parameter int DIV   = 4194304
) (
  input logic             clk,
  input logic             rstN,
  car_light_ctrl_if.slave bus
);
  // state  | meaning
  // IDLE   | no indication, green status LED steady
  // LEFT   | upper half fills from centre outward, amber blink
  // RIGHT  | lower half fills from centre outward, amber blink
  // HAZARD | all chaser LEDs and red status LED blink together
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } lightState;

  localparam int HALF = LED_N / 2;
  localparam int TW   = $clog2(DIV);
  localparam int SW   = $clog2(HALF + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(HALF);

  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [1:0]       modeMeta;
  logic [1:0]       modeS;
  logic [1:0]       cand;
  logic             accept;
  lightState        state;
  lightState        nxtState;
  logic [SW-1:0]    step;
  logic [SW-1:0]    nxtStep;
  logic             phase;
  logic             nxtPhase;
  logic [LED_N-1:0] waterMask;
  logic [2:0]       rgbMask;

  assign tick   = (tcnt == TCNT_LAST);
  // A mode is taken only once it has been seen identical on two consecutive ticks.
  assign accept = tick && (modeS == cand) && (modeS != state);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      modeMeta <= 2'd0;
      modeS    <= 2'd0;
      cand     <= 2'd0;
    end else begin
      modeMeta <= bus.mode;
      modeS    <= modeMeta;
      if (tick) begin
        cand <= modeS;
      end
    end
  end

  always_comb begin
    nxtState = state;
    nxtStep  = step;
    nxtPhase = phase;
    if (tick) begin
      nxtPhase = ~phase;
      if (accept) begin
        nxtState = lightState'(modeS);
        nxtStep  = '0;
      end else if (state == LEFT || state == RIGHT) begin
        nxtStep = (step == STEP_LAST) ? '0 : step + SW'(1);
      end else begin
        nxtStep = '0;
      end
    end
  end

  // Output masks are built from the next-state values so LEDs change on the tick edge itself.
  always_comb begin
    waterMask = '0;
    rgbMask   = 3'b000;
    case (nxtState)
      IDLE: begin
        rgbMask = 3'b010;
      end
      LEFT: begin
        for (int i = 0; i < HALF; i++) begin
          waterMask[HALF + i] = (SW'(i) < nxtStep);
        end
        rgbMask = nxtPhase ? 3'b110 : 3'b000;
      end
      RIGHT: begin
        for (int i = 0; i < HALF; i++) begin
          waterMask[HALF - 1 - i] = (SW'(i) < nxtStep);
        end
        rgbMask = nxtPhase ? 3'b110 : 3'b000;
      end
      HAZARD: begin
        waterMask = {LED_N{nxtPhase}};
        rgbMask   = nxtPhase ? 3'b100 : 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      step         <= '0;
      phase        <= 1'b0;
      bus.ledWater <= '1;
      bus.ledRGB   <= 3'b101;
      bus.stateOut <= 2'd0;
    end else begin
      state        <= nxtState;
      step         <= nxtStep;
      phase        <= nxtPhase;
      bus.ledWater <= ~waterMask;
      bus.ledRGB   <= ~rgbMask;
      bus.stateOut <= nxtState;
    end
  end
endmodule

// File: tb/tb_car_light_ctrl.sv
// Bench for car_light_ctrl: directed vector table on an 8-LED/DIV=4 instance,
// wide/slow instance checks, and random mode traffic against a tick-level model.
module tb_car_light_ctrl;
  localparam int LN = 8;
  localparam int DV = 4;

  logic clk;
  logic rstN;
  int   checks;
  int   failures;

  car_light_ctrl_if #(.LED_N(8))  m8();
  car_light_ctrl_if #(.LED_N(16)) m16();

  car_light_ctrl #(.LED_N(8), .DIV(4)) dut8 (
    .clk(clk), .rstN(rstN), .bus(m8)
  );
  car_light_ctrl #(.LED_N(16), .DIV(10)) dut16 (
    .clk(clk), .rstN(rstN), .bus(m16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] water;
    logic [2:0] rgb;
    logic [1:0] st;
  } vecT;
  vecT vecs[25];

  // Reference model: edge count since release decides ticks; modeS is mode two edges ago.
  int mEdges;
  int mDly0, mDly1;
  int mCand, mState, mStep, mPhase, mS;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mEdges = 0; mDly0 = 0; mDly1 = 0;
      mCand = 0; mState = 0; mStep = 0; mPhase = 0;
    end else begin
      if (mEdges % DV == DV - 1) begin
        mS = mDly1;
        if (mS == mCand && mS != mState) begin
          mState = mS;
          mStep  = 0;
        end else if (mState == 1 || mState == 2) begin
          mStep = (mStep + 1) % (LN / 2 + 1);
        end else begin
          mStep = 0;
        end
        mCand  = mS;
        mPhase = 1 - mPhase;
      end
      mDly1 = mDly0;
      mDly0 = int'(m8.mode);
      mEdges++;
    end
  end

  function automatic logic [7:0] expWater(int st, int stp, int ph);
    longint fill;
    fill = (longint'(1) << stp) - 1;
    case (st)
      1:       return ~8'(fill << (LN / 2));
      2:       return ~8'(fill << (LN / 2 - stp));
      3:       return (ph != 0) ? 8'h00 : 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] expRgb(int st, int ph);
    case (st)
      1, 2:    return (ph != 0) ? 3'b001 : 3'b111;
      3:       return (ph != 0) ? 3'b011 : 3'b111;
      default: return 3'b101;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tickWait(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int holdLeft;
    logic [15:0] exp16;
    checks = 0;
    failures = 0;

    vecs[0]  = '{2'd1, 8'hFF, 3'b101, 2'd0};
    vecs[1]  = '{2'd1, 8'hFF, 3'b111, 2'd1};
    vecs[2]  = '{2'd1, 8'hEF, 3'b001, 2'd1};
    vecs[3]  = '{2'd1, 8'hCF, 3'b111, 2'd1};
    vecs[4]  = '{2'd1, 8'h8F, 3'b001, 2'd1};
    vecs[5]  = '{2'd1, 8'h0F, 3'b111, 2'd1};
    vecs[6]  = '{2'd1, 8'hFF, 3'b001, 2'd1};
    vecs[7]  = '{2'd1, 8'hEF, 3'b111, 2'd1};
    vecs[8]  = '{2'd2, 8'hCF, 3'b001, 2'd1};
    vecs[9]  = '{2'd2, 8'hFF, 3'b111, 2'd2};
    vecs[10] = '{2'd2, 8'hF7, 3'b001, 2'd2};
    vecs[11] = '{2'd2, 8'hF3, 3'b111, 2'd2};
    vecs[12] = '{2'd2, 8'hF1, 3'b001, 2'd2};
    vecs[13] = '{2'd2, 8'hF0, 3'b111, 2'd2};
    vecs[14] = '{2'd2, 8'hFF, 3'b001, 2'd2};
    vecs[15] = '{2'd2, 8'hF7, 3'b111, 2'd2};
    vecs[16] = '{2'd1, 8'hF3, 3'b001, 2'd2};
    vecs[17] = '{2'd1, 8'hFF, 3'b111, 2'd1};
    vecs[18] = '{2'd1, 8'hEF, 3'b001, 2'd1};
    vecs[19] = '{2'd3, 8'hCF, 3'b111, 2'd1};
    vecs[20] = '{2'd3, 8'h00, 3'b011, 2'd3};
    vecs[21] = '{2'd3, 8'hFF, 3'b111, 2'd3};
    vecs[22] = '{2'd3, 8'h00, 3'b011, 2'd3};
    vecs[23] = '{2'd0, 8'hFF, 3'b111, 2'd3};
    vecs[24] = '{2'd0, 8'hFF, 3'b101, 2'd0};

    rstN = 1'b0;
    m8.mode = 2'd0;
    m16.mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("reset_water", 32'(m8.ledWater), 32'h0FF);
    chk("reset_rgb", 32'(m8.ledRGB), 32'b101);
    chk("reset_state", 32'(m8.stateOut), 32'd0);
    rstN = 1'b1;

    for (int k = 0; k < 25; k++) begin
      m8.mode = vecs[k].mode;
      tickWait(DV);
      chk($sformatf("vec%0d_water", k), 32'(m8.ledWater), 32'(vecs[k].water));
      chk($sformatf("vec%0d_rgb", k), 32'(m8.ledRGB), 32'(vecs[k].rgb));
      chk($sformatf("vec%0d_state", k), 32'(m8.stateOut), 32'(vecs[k].st));
    end

    // Reset mid-sweep must act without a clock edge, then restart from IDLE.
    m8.mode = 2'd1;
    repeat (3) tickWait(DV);
    chk("presweep_water", 32'(m8.ledWater), 32'h0EF);
    #2 rstN = 1'b0;
    #1;
    chk("async_rst_water", 32'(m8.ledWater), 32'h0FF);
    chk("async_rst_rgb", 32'(m8.ledRGB), 32'b101);
    chk("async_rst_state", 32'(m8.stateOut), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    tickWait(DV);
    chk("restart_idle_state", 32'(m8.stateOut), 32'd0);
    tickWait(DV);
    chk("restart_accept_state", 32'(m8.stateOut), 32'd1);

    // Debounce: a 3-clk pulse between ticks is never accepted.
    rstN = 1'b0;
    m8.mode = 2'd0;
    @(negedge clk);
    rstN = 1'b1;
    tickWait(DV);
    m8.mode = 2'd1;
    repeat (3) @(negedge clk);
    m8.mode = 2'd0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tickWait(DV);
      chk($sformatf("glitch_state%0d", k), 32'(m8.stateOut), 32'd0);
    end
    chk("glitch_rgb", 32'(m8.ledRGB), 32'b101);
    m8.mode = 2'd1;
    tickWait(DV);
    tickWait(DV);
    chk("held_mode_state", 32'(m8.stateOut), 32'd1);

    // 16 LEDs, DIV=10: spacing of ticks and full-half fill then wrap.
    rstN = 1'b0;
    m16.mode = 2'd1;
    @(negedge clk);
    rstN = 1'b1;
    tickWait(10);
    chk("w16_t1_state", 32'(m16.stateOut), 32'd0);
    tickWait(10);
    chk("w16_t2_state", 32'(m16.stateOut), 32'd1);
    chk("w16_t2_water", 32'(m16.ledWater), 32'hFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("w16_pre_tick_water", 32'(m16.ledWater), 32'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("w16_step1_water", 32'(m16.ledWater), 32'hFEFF);
    for (int s = 2; s <= 8; s++) begin
      tickWait(10);
      exp16 = ~(16'((32'd1 << s) - 1) << 8);
      chk($sformatf("w16_step%0d_water", s), 32'(m16.ledWater), 32'(exp16));
    end
    tickWait(10);
    chk("w16_wrap_water", 32'(m16.ledWater), 32'hFFFF);
    chk("w16_wrap_state", 32'(m16.stateOut), 32'd1);

    // Random mode traffic against the reference model, with one mid-run reset.
    rstN = 1'b0;
    m8.mode = 2'd0;
    m16.mode = 2'd0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    holdLeft = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rnd_water", 32'(m8.ledWater), 32'(expWater(mState, mStep, mPhase)));
      chk("rnd_rgb", 32'(m8.ledRGB), 32'(expRgb(mState, mPhase)));
      chk("rnd_state", 32'(m8.stateOut), 32'(mState));
      if (holdLeft == 0) begin
        m8.mode = 2'($urandom_range(0, 3));
        holdLeft = int'($urandom_range(1, 14));
      end else begin
        holdLeft--;
      end
      if (c == 700) rstN = 1'b0;
      if (c == 703) rstN = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
